// File: rtl/pavan_hbps_pkg.sv
// Shared types and constants for the handshake pulse scheduler.
// Holds the FSM state encoding, counter widths and parameter defaults.
package pavan_hbps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRE  = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP_W = 3'd4
    } state_e;

    localparam int DROP_W     = 8;
    localparam int WD_W       = 16;
    localparam int GAP_CNT_W  = 4;

    localparam int DEF_CNT_W  = 4;
    localparam int DEF_GAP    = 0;
    localparam int DEF_TO_CYC = 255;

endpackage

// File: rtl/pavan_hbps_pulse_scheduler_if.sv
// Event/busy/status bundle between the scheduler and its clk_a-side user.
// The master drives events, busy and clear; the scheduler is the slave.
interface pavan_hbps_pulse_scheduler_if
    import pavan_hbps_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic              ev_in;
    logic              busy;
    logic              clr_err;
    logic              pulse_out;
    logic [CNT_W-1:0]  pending;
    logic              full;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              timeout_err;

    modport master (
        output ev_in, busy, clr_err,
        input  pulse_out, pending, full, overflow, drop_cnt, timeout_err
    );

    modport slave (
        input  ev_in, busy, clr_err,
        output pulse_out, pending, full, overflow, drop_cnt, timeout_err
    );
endinterface

// File: rtl/pavan_sat_counter.sv
// Up/down counter that sticks at zero and at all-ones instead of wrapping.
// clr_i beats any simultaneous inc/dec.
module pavan_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pavan_hbps_pulse_scheduler.sv
// Queues bursty events and issues them one at a time as single-cycle pulses,
// only while the downstream handshake synchronizer reports not-busy.
module pavan_hbps_pulse_scheduler
    import pavan_hbps_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP    = DEF_GAP,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic                          clk_a,
    input  logic                          rst,
    pavan_hbps_pulse_scheduler_if.slave   bus
);
    localparam logic [CNT_W-1:0]     PEND_MAX = '1;
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TO_CYC - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e                 state_q;
    logic                   pulse_q;
    logic                   ovf_q;
    logic                   to_q;
    logic [WD_W-1:0]        wd_q;
    logic [GAP_CNT_W-1:0]   gap_q;

    logic [CNT_W-1:0]       pend;
    logic [DROP_W-1:0]      drops;
    logic                   fire;
    logic                   full;
    logic                   drop;
    logic                   accept;

    // An event arriving while full survives only if a pulse frees a slot this cycle.
    assign fire   = (state_q == ST_FIRE);
    assign full   = (pend == PEND_MAX);
    assign drop   = bus.ev_in & full & ~fire;
    assign accept = bus.ev_in & ~drop;

    pavan_sat_counter #(.W(CNT_W)) u_pending (
        .clk   (clk_a),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (accept),
        .dec_i (fire),
        .cnt_o (pend)
    );

    pavan_sat_counter #(.W(DROP_W)) u_drops (
        .clk   (clk_a),
        .rst   (rst),
        .clr_i (bus.clr_err),
        .inc_i (drop),
        .dec_i (1'b0),
        .cnt_o (drops)
    );

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend != '0 && !bus.busy) begin
                        state_q <= ST_FIRE;
                        pulse_q <= 1'b1;
                    end
                end
                ST_FIRE: state_q <= ST_ARM;
                // busy only rises the edge after the pulse, so skip one cycle
                ST_ARM:  state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (!bus.busy) begin
                        wd_q    <= '0;
                        gap_q   <= '0;
                        state_q <= (GAP > 0) ? ST_GAP_W : ST_IDLE;
                    end else if (wd_q == WD_LAST) begin
                        to_q    <= 1'b1;
                        wd_q    <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_GAP_W: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                to_q  <= 1'b0;
            end
        end
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.pending     = pend;
    assign bus.full        = full;
    assign bus.overflow    = ovf_q;
    assign bus.drop_cnt    = drops;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_pavan_hbps_pulse_scheduler.sv
// Randomised self-checking bench for the pulse scheduler against a
// behavioural model of pending count, handshake phase and error flags.
module tb_pavan_hbps_pulse_scheduler;
    localparam int CNT_W  = 4;
    localparam int GAP    = 2;
    localparam int TO_CYC = 20;
    localparam int PMAX   = (1 << CNT_W) - 1;

    localparam int PH_FREE = 0, PH_ARMING = 1, PH_HANDSHAKE = 2, PH_COOL = 3;

    logic clk_a = 1'b0;
    logic rst   = 1'b1;

    pavan_hbps_pulse_scheduler_if #(.CNT_W(CNT_W)) bus_if ();

    pavan_hbps_pulse_scheduler #(.CNT_W(CNT_W), .GAP(GAP), .TO_CYC(TO_CYC)) dut (
        .clk_a (clk_a),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 clk_a = ~clk_a;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_pulses = 0;

    // model of what the DUT should show in the current cycle
    bit m_valid = 0;
    int m_pend, m_drop, m_phase, m_wd, m_gap;
    bit m_pulse, m_ovf, m_to;

    // busy generator: 0 follows pulses, 1 forced high, 2 forced low
    int bmode = 0;
    int b_left = 0;
    int blen = 3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        if (m_valid) begin
            check_eq("pulse_out",   32'(bus_if.pulse_out),   32'(m_pulse));
            check_eq("pending",     32'(bus_if.pending),     32'(m_pend));
            check_eq("full",        32'(bus_if.full),        32'(m_pend == PMAX));
            check_eq("overflow",    32'(bus_if.overflow),    32'(m_ovf));
            check_eq("drop_cnt",    32'(bus_if.drop_cnt),    32'(m_drop));
            check_eq("timeout_err", 32'(bus_if.timeout_err), 32'(m_to));
        end
        if (bus_if.pulse_out === 1'b1) dut_pulses++;
    endtask

    task automatic model_advance(input bit ev, input bit b, input bit clr, input bit rs);
        bit dec, drp, tmo, nxt_pulse;
        int nxt_pend;
        if (rs) begin
            m_pend = 0; m_drop = 0; m_phase = PH_FREE; m_wd = 0; m_gap = 0;
            m_pulse = 0; m_ovf = 0; m_to = 0;
            m_valid = 1;
        end else begin
            dec = m_pulse;
            drp = ev && (m_pend == PMAX) && !dec;
            nxt_pend = m_pend + ((ev && !drp) ? 1 : 0) - (dec ? 1 : 0);
            tmo = 0;
            nxt_pulse = 0;
            if (m_pulse) begin
                m_phase = PH_ARMING;
            end else begin
                case (m_phase)
                    PH_FREE:   nxt_pulse = (m_pend > 0) && !b;
                    PH_ARMING: begin m_phase = PH_HANDSHAKE; m_wd = 0; end
                    PH_HANDSHAKE: begin
                        if (!b) begin
                            m_phase = (GAP > 0) ? PH_COOL : PH_FREE;
                            m_gap = 0;
                        end else if (m_wd + 1 >= TO_CYC) begin
                            tmo = 1; m_wd = 0; m_phase = PH_FREE;
                        end else begin
                            m_wd++;
                        end
                    end
                    default: begin
                        m_gap++;
                        if (m_gap >= GAP) m_phase = PH_FREE;
                    end
                endcase
            end
            if (clr) begin
                m_ovf = 0; m_to = 0; m_drop = 0;
            end else begin
                if (drp) m_ovf = 1;
                if (tmo) m_to = 1;
                if (drp && m_drop < 255) m_drop++;
            end
            m_pend = nxt_pend;
            m_pulse = nxt_pulse;
        end
    endtask

    // one clock cycle: check current outputs, apply inputs, advance model
    task automatic step(input bit ev, input bit clr, input bit rs);
        bit b;
        check_all();
        case (bmode)
            1:       b = 1;
            2:       b = 0;
            default: b = (b_left > 0);
        endcase
        if (m_pulse) b_left = blen;
        else if (b_left > 0) b_left--;
        bus_if.ev_in   = ev;
        bus_if.busy    = b;
        bus_if.clr_err = clr;
        rst            = rs;
        model_advance(ev, b, clr, rs);
        @(negedge clk_a);
    endtask

    initial begin
        int p0;
        bit coinc_done;
        bus_if.ev_in = 0; bus_if.busy = 0; bus_if.clr_err = 0;
        @(negedge clk_a);

        // reset and single event latency
        step(0, 0, 1);
        check_eq("rst_pending", 32'(bus_if.pending), 0);
        check_eq("rst_pulse", 32'(bus_if.pulse_out), 0);
        step(0, 0, 1);
        blen = 6;
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        step(1, 0, 0);
        check_eq("lat_pend_n1", 32'(bus_if.pending), 1);
        check_eq("lat_pulse_n1", 32'(bus_if.pulse_out), 0);
        step(0, 0, 0);
        check_eq("lat_pulse_n2", 32'(bus_if.pulse_out), 1);
        step(0, 0, 0);
        check_eq("lat_pend_n3", 32'(bus_if.pending), 0);
        check_eq("lat_pulse_n3", 32'(bus_if.pulse_out), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // burst of five
        p0 = dut_pulses;
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 80; i++) step(0, 0, 0);
        check_eq("burst_pulses", 32'(dut_pulses - p0), 5);
        check_eq("burst_pend", 32'(bus_if.pending), 0);

        // fill past full with busy held high
        blen = 3;
        bmode = 1;
        p0 = dut_pulses;
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        check_eq("fill_pend", 32'(bus_if.pending), 15);
        check_eq("fill_full", 32'(bus_if.full), 1);
        check_eq("fill_ovf", 32'(bus_if.overflow), 1);
        check_eq("fill_drops", 32'(bus_if.drop_cnt), 5);
        check_eq("fill_pulses", 32'(dut_pulses - p0), 0);

        // drain, with one event landing on the first FIRE while full
        bmode = 0; b_left = 0;
        coinc_done = 0;
        p0 = dut_pulses;
        for (int i = 0; i < 250; i++) begin
            if (!coinc_done && m_pulse) begin
                coinc_done = 1;
                step(1, 0, 0);
                check_eq("coinc_pend", 32'(bus_if.pending), 15);
                check_eq("coinc_drops", 32'(bus_if.drop_cnt), 5);
            end else begin
                step(0, 0, 0);
            end
        end
        check_eq("drain_pulses", 32'(dut_pulses - p0), 16);
        check_eq("drain_pend", 32'(bus_if.pending), 0);

        // busy stuck high after a pulse -> watchdog
        step(1, 0, 0);
        for (int i = 0; i < 5 && !m_pulse; i++) step(0, 0, 0);
        bmode = 1;
        for (int i = 0; i < 30; i++) step(0, 0, 0);
        check_eq("wd_timeout", 32'(bus_if.timeout_err), 1);
        step(0, 1, 0);
        check_eq("clr_timeout", 32'(bus_if.timeout_err), 0);
        check_eq("clr_drops", 32'(bus_if.drop_cnt), 0);
        check_eq("clr_ovf", 32'(bus_if.overflow), 0);
        bmode = 0; b_left = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // reset while waiting on a long handshake with 7 queued
        blen = 50;
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check_eq("pre_rst_pend", 32'(bus_if.pending), 7);
        step(0, 0, 1);
        check_eq("post_rst_pend", 32'(bus_if.pending), 0);
        check_eq("post_rst_pulse", 32'(bus_if.pulse_out), 0);
        b_left = 0; blen = 3;
        p0 = dut_pulses;
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check_eq("post_rst_pulses", 32'(dut_pulses - p0), 1);

        // randomised traffic
        for (int blk = 0; blk < 20; blk++) begin
            int ev_pct;
            ev_pct = $urandom_range(5, 90);
            for (int i = 0; i < 100; i++) begin
                bit ev, clr, rs;
                ev  = ($urandom_range(0, 99) < ev_pct);
                clr = ($urandom_range(0, 63) == 0);
                rs  = ($urandom_range(0, 499) == 0);
                if (m_pulse) blen = $urandom_range(1, 8);
                if (bmode == 0 && $urandom_range(0, 199) == 0) bmode = 1;
                else if (bmode == 1 && $urandom_range(0, 29) == 0) bmode = 0;
                step(ev, clr, rs);
            end
        end
        bmode = 0;
        for (int i = 0; i < 200; i++) step(0, 0, 0);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
